store_commit_unit: RTL and testbench

Store commit unit at the far end of the LSQ retire interface. It accepts retired LSQ entries and buffers committed stores in a small in-order store buffer. It drains those stores into a single-port byte-writable data RAM and arbitrates that RAM port with load requests from the memory FU. Loads never read a word that still has a pending store in the buffer.

---
 rtl/store_commit_unit_pkg.sv | 43 ++++
 rtl/store_commit_unit_if.sv | 26 ++
 rtl/store_commit_unit_dmem_sram.sv | 27 ++
 rtl/store_commit_unit.sv | 135 +++++++++++++
 tb/tb_store_commit_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_commit_unit_pkg.sv
// Shared types and constants for the store commit unit.
// - lsq        : retired LSQ entry as presented on the retire interface
// - sb_entry_t : one store-buffer slot (word index, write data, byte enables)
// - opcode/func3 constants and the load-result alignment helper
package store_commit_unit_pkg;

    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [2:0] F3_LW    = 3'b010;
    localparam logic [2:0] F3_LBU   = 3'b100;
    localparam logic [2:0] F3_SW    = 3'b010;
    localparam logic [2:0] F3_SH    = 3'b001;

    // sw_sh_signal carries the store func3 (F3_SW or F3_SH); anything
    // other than F3_SH is handled as a word store.
    typedef struct packed {
        logic        valid;
        logic        store;
        logic [2:0]  sw_sh_signal;
        logic [31:0] addr;
        logic [31:0] ps2_data;
        logic [6:0]  pd;
        logic [4:0]  rob_tag;
    } lsq;

    // word_idx is held zero-extended to 30 bits; only the low
    // log2(MEM_WORDS) bits are ever non-zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] word_idx;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        if (f3 == F3_LBU) begin
            return {24'b0, word[8*off +: 8]};
        end
        return word;
    endfunction

endpackage

// File: rtl/store_commit_unit_if.sv
// Load request/response channel between the memory FU and the store
// commit unit.
// - master : FU side (drives request, receives ready and result)
// - slave  : store commit unit side
interface store_commit_unit_if;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_func3;
    logic [6:0]  ld_pd;
    logic [4:0]  ld_rob_tag;
    logic        ld_ready;
    logic        ld_done;
    logic [31:0] ld_data;
    logic [6:0]  ld_pd_out;
    logic [4:0]  ld_rob_tag_out;

    modport master (
        output ld_valid, ld_addr, ld_func3, ld_pd, ld_rob_tag,
        input  ld_ready, ld_done, ld_data, ld_pd_out, ld_rob_tag_out
    );

    modport slave (
        input  ld_valid, ld_addr, ld_func3, ld_pd, ld_rob_tag,
        output ld_ready, ld_done, ld_data, ld_pd_out, ld_rob_tag_out
    );
endinterface

// File: rtl/store_commit_unit_dmem_sram.sv
// Single-port data RAM, MEM_WORDS x 32, per-byte write enable,
// synchronous read with one-cycle latency, contents not reset.
// - clk   : clock
// - we    : byte write enables
// - addr  : word index
// - wdata : write data
// - rdata : registered read data
module dmem_sram #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic [3:0]                   we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);
    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/store_commit_unit.sv
// Store commit unit: buffers retired stores in an in-order store buffer,
// drains them into the data RAM and shares the RAM port with loads.
// - clk, reset    : clock, synchronous active-high reset
// - store_wb      : retire pulse; commit_entry is the retired LSQ entry
// - sb_full       : store buffer full
// - ld            : load request/result channel (slave side)
// - overflow_err  : sticky, retire arrived while full
// - misalign_err  : sticky, misaligned store dropped
module store_commit_unit
    import store_commit_unit_pkg::*;
#(
    parameter int unsigned SB_DEPTH  = 4,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      store_wb,
    input  lsq                        commit_entry,
    output logic                      sb_full,
    store_commit_unit_if.slave        ld,
    output logic                      overflow_err,
    output logic                      misalign_err
);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    sb_entry_t      sb [SB_DEPTH];
    logic [PW-1:0]  head, tail;
    logic [PW:0]    count;

    logic           full;
    logic           store_retire, aligned, push, pop, conflict, ld_go;
    logic [29:0]    push_idx, ld_idx;
    logic [31:0]    push_wdata;
    logic [3:0]     push_be;

    logic           ld_done_q;
    logic [1:0]     ld_off_q;
    logic [2:0]     ld_f3_q;
    logic [31:0]    ram_rdata;

    logic           unused_bits;
    assign unused_bits = ^{commit_entry.valid, commit_entry.pd,
                           commit_entry.rob_tag, commit_entry.addr, ld.ld_addr};

    assign full    = (count == (PW+1)'(SB_DEPTH));
    assign sb_full = full;

    always_comb begin
        push_idx   = 30'(commit_entry.addr[AW+1:2]);
        ld_idx     = 30'(ld.ld_addr[AW+1:2]);
        push_be    = 4'b1111;
        push_wdata = commit_entry.ps2_data;
        aligned    = (commit_entry.addr[1:0] == 2'b00);
        if (commit_entry.sw_sh_signal == F3_SH) begin
            push_wdata = {2{commit_entry.ps2_data[15:0]}};
            aligned    = ~commit_entry.addr[0];
            push_be    = commit_entry.addr[1] ? 4'b1100 : 4'b0011;
        end

        store_retire = store_wb & commit_entry.store & ~reset;
        push         = store_retire & aligned & ~full;

        // The entry entering this cycle counts as pending too, otherwise a
        // load could overtake a store retired in the same cycle.
        conflict = push & (push_idx == ld_idx);
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb[i].valid && (sb[i].word_idx == ld_idx)) begin
                conflict = 1'b1;
            end
        end

        // A full buffer always takes the port, so stores cannot starve.
        ld_go = ld.ld_valid & ~conflict & ~full & ~reset;
        pop   = ~ld_go & (count != '0) & ~reset;
    end

    assign ld.ld_ready = ld_go;

    dmem_sram #(.MEM_WORDS(MEM_WORDS)) u_dmem (
        .clk   (clk),
        .we    (pop ? sb[head].be : 4'b0000),
        .addr  (ld_go ? ld_idx[AW-1:0] : sb[head].word_idx[AW-1:0]),
        .wdata (sb[head].wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            overflow_err   <= 1'b0;
            misalign_err   <= 1'b0;
            ld_done_q      <= 1'b0;
            ld_off_q       <= '0;
            ld_f3_q        <= '0;
            ld.ld_pd_out   <= '0;
            ld.ld_rob_tag_out <= '0;
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                sb[i].valid <= 1'b0;
            end
        end else begin
            if (pop) begin
                sb[head].valid <= 1'b0;
                head           <= head + 1'b1;
            end
            if (push) begin
                sb[tail] <= '{valid: 1'b1, word_idx: push_idx,
                              wdata: push_wdata, be: push_be};
                tail     <= tail + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

            if (store_wb && full) begin
                overflow_err <= 1'b1;
            end
            if (store_retire && !aligned) begin
                misalign_err <= 1'b1;
            end

            ld_done_q <= ld_go;
            if (ld_go) begin
                ld_off_q          <= ld.ld_addr[1:0];
                ld_f3_q           <= ld.ld_func3;
                ld.ld_pd_out      <= ld.ld_pd;
                ld.ld_rob_tag_out <= ld.ld_rob_tag;
            end
        end
    end

    assign ld.ld_done = ld_done_q;
    assign ld.ld_data = ld_done_q ? align_load(ram_rdata, ld_off_q, ld_f3_q) : '0;

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed self-checking bench for store_commit_unit.
module tb_store_commit_unit;
    import store_commit_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic store_wb;
    lsq   ce;
    logic sb_full, overflow_err, misalign_err;
    int   n_checks = 0;
    int   n_fail   = 0;

    store_commit_unit_if lif ();

    store_commit_unit #(.SB_DEPTH(4), .MEM_WORDS(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .store_wb     (store_wb),
        .commit_entry (ce),
        .sb_full      (sb_full),
        .ld           (lif),
        .overflow_err (overflow_err),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic sh);
        store_wb        = 1'b1;
        ce              = '0;
        ce.valid        = 1'b1;
        ce.store        = 1'b1;
        ce.addr         = a;
        ce.ps2_data     = d;
        ce.sw_sh_signal = sh ? F3_SH : F3_SW;
    endtask

    task automatic clr_store;
        store_wb = 1'b0;
        ce       = '0;
    endtask

    task automatic store_drain(input logic [31:0] a, input logic [31:0] d, input logic sh);
        set_store(a, d, sh);
        tick;
        clr_store;
        tick;
        tick;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] f3);
        lif.ld_valid   = 1'b1;
        lif.ld_addr    = a;
        lif.ld_func3   = f3;
        lif.ld_pd      = a[6:0] ^ 7'h2A;
        lif.ld_rob_tag = a[6:2];
    endtask

    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] exp);
        bit acc = 0;
        set_load(a, f3);
        for (int i = 0; i < 8 && !acc; i++) begin
            #1;
            if (lif.ld_ready === 1'b1) acc = 1;
            else tick;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s accept: ld_ready never 1, required 1", nm);
            lif.ld_valid = 1'b0;
            tick;
        end else begin
            tick;
            lif.ld_valid = 1'b0;
            n_checks++;
            if (lif.ld_done !== 1'b1) begin
                n_fail++; $display("FAIL %s done: got %b exp 1", nm, lif.ld_done);
            end
            n_checks++;
            if (lif.ld_data !== exp) begin
                n_fail++; $display("FAIL %s data: got %h exp %h", nm, lif.ld_data, exp);
            end
            n_checks++;
            if (lif.ld_pd_out !== (a[6:0] ^ 7'h2A) || lif.ld_rob_tag_out !== a[6:2]) begin
                n_fail++;
                $display("FAIL %s tags: got pd %h tag %h exp pd %h tag %h", nm,
                         lif.ld_pd_out, lif.ld_rob_tag_out, a[6:0] ^ 7'h2A, a[6:2]);
            end
            tick;
            n_checks++;
            if (lif.ld_done !== 1'b0) begin
                n_fail++; $display("FAIL %s done_pulse: got %b exp 0", nm, lif.ld_done);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clr_store;
        lif.ld_valid = 1'b0; lif.ld_addr = '0; lif.ld_func3 = '0;
        lif.ld_pd = '0; lif.ld_rob_tag = '0;
        tick; tick;
        reset = 1'b0;
        n_checks++;
        if ({sb_full, lif.ld_done, overflow_err, misalign_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 0000",
                     {sb_full, lif.ld_done, overflow_err, misalign_err});
        end
        n_checks++;
        if (lif.ld_data !== 32'h0 || lif.ld_pd_out !== 7'h0 || lif.ld_rob_tag_out !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h %h %h exp 0 0 0",
                     lif.ld_data, lif.ld_pd_out, lif.ld_rob_tag_out);
        end
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_sw_lw;
        set_store(32'h10, 32'hDEADBEEF, 1'b0);
        tick;
        clr_store;
        repeat (4) tick;
        do_load("lw_0x10", 32'h10, F3_LW, 32'hDEADBEEF);
    endtask

    task automatic test_sh_lbu;
        store_drain(32'h12, 32'h0000CAFE, 1'b1);
        do_load("lbu_0x13", 32'h13, F3_LBU, 32'h000000CA);
        do_load("lbu_0x10", 32'h10, F3_LBU, 32'h000000EF);
        do_load("lw_0x10_after_sh", 32'h10, F3_LW, 32'hCAFEBEEF);
    endtask

    task automatic test_conflict;
        store_drain(32'h40, 32'h40404040, 1'b0);
        set_store(32'h20, 32'h12345678, 1'b0);
        set_load(32'h20, F3_LW);
        #1;
        n_checks++;
        if (lif.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL conflict_push_cycle: ld_ready %b exp 0", lif.ld_ready);
        end
        tick;
        clr_store;
        #1;
        n_checks++;
        if (lif.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL conflict_drain_cycle: ld_ready %b exp 0", lif.ld_ready);
        end
        tick;
        lif.ld_valid = 1'b0;
        do_load("lw_0x20_after_drain", 32'h20, F3_LW, 32'h12345678);

        set_store(32'h24, 32'h0BADF00D, 1'b0);
        set_load(32'h40, F3_LW);
        #1;
        n_checks++;
        if (lif.ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL no_conflict_ready: ld_ready %b exp 1", lif.ld_ready);
        end
        tick;
        clr_store;
        lif.ld_valid = 1'b0;
        n_checks++;
        if (lif.ld_done !== 1'b1 || lif.ld_data !== 32'h40404040) begin
            n_fail++;
            $display("FAIL no_conflict_data: done %b data %h exp 1 40404040",
                     lif.ld_done, lif.ld_data);
        end
        tick; tick;
        do_load("lw_0x24", 32'h24, F3_LW, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back;
        store_drain(32'h80, 32'h80808080, 1'b0);
        store_drain(32'h110, 32'h11111111, 1'b0);
        set_load(32'h80, F3_LW);
        for (int i = 0; i < 4; i++) begin
            set_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
            #1;
            n_checks++;
            if (lif.ld_ready !== 1'b1 || sb_full !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_fill%0d: ready %b full %b exp 1 0", i, lif.ld_ready, sb_full);
            end
            tick;
        end
        set_store(32'h110, 32'hFFFFFFFF, 1'b0);
        n_checks++;
        if (sb_full !== 1'b1) begin
            n_fail++; $display("FAIL b2b_full: sb_full %b exp 1", sb_full);
        end
        n_checks++;
        if (lif.ld_done !== 1'b1 || lif.ld_data !== 32'h80808080) begin
            n_fail++;
            $display("FAIL b2b_held_load: done %b data %h exp 1 80808080", lif.ld_done, lif.ld_data);
        end
        #1;
        n_checks++;
        if (lif.ld_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_full_ready: ld_ready %b exp 0", lif.ld_ready);
        end
        tick;
        clr_store;
        n_checks++;
        if (overflow_err !== 1'b1 || sb_full !== 1'b0 || lif.ld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_after_full: ovf %b full %b done %b exp 1 0 0",
                     overflow_err, sb_full, lif.ld_done);
        end
        n_checks++;
        if (dut.count !== 3'd3) begin
            n_fail++; $display("FAIL b2b_count: got %0d exp 3", dut.count);
        end
        #1;
        n_checks++;
        if (lif.ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_back: ld_ready %b exp 1", lif.ld_ready);
        end
        lif.ld_valid = 1'b0;
        repeat (5) tick;
        do_load("lw_0x110_unchanged", 32'h110, F3_LW, 32'h11111111);
        do_load("lw_0x100", 32'h100, F3_LW, 32'hA000_0000);
        do_load("lw_0x10c", 32'h10C, F3_LW, 32'hA000_0003);
    endtask

    task automatic test_misalign_nonstore;
        set_load(32'h80, F3_LW);
        set_store(32'h200, 32'h00000200, 1'b0);
        tick;
        store_wb = 1'b1;
        ce.store = 1'b0;
        ce.addr  = 32'h204;
        tick;
        n_checks++;
        if (dut.count !== 3'd1) begin
            n_fail++; $display("FAIL retire_load_count: got %0d exp 1", dut.count);
        end
        set_store(32'h22, 32'h55555555, 1'b0);
        tick;
        clr_store;
        n_checks++;
        if (misalign_err !== 1'b1 || dut.count !== 3'd1) begin
            n_fail++;
            $display("FAIL misalign: err %b count %0d exp 1 1", misalign_err, dut.count);
        end
        lif.ld_valid = 1'b0;
        repeat (3) tick;
        do_load("lw_0x20_after_misalign", 32'h20, F3_LW, 32'h12345678);
    endtask

    task automatic test_reset_midflight;
        set_load(32'h80, F3_LW);
        for (int i = 0; i < 3; i++) begin
            set_store(32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0);
            tick;
        end
        clr_store;
        reset = 1'b1;
        n_checks++;
        if (dut.count !== 3'd3 || lif.ld_done !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: count %0d done %b exp 3 1", dut.count, lif.ld_done);
        end
        tick;
        reset = 1'b0;
        lif.ld_valid = 1'b0;
        n_checks++;
        if (dut.count !== 3'd0 || sb_full !== 1'b0 || lif.ld_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: count %0d full %b done %b exp 0 0 0",
                     dut.count, sb_full, lif.ld_done);
        end
        n_checks++;
        if (overflow_err !== 1'b0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_errs: ovf %b mis %b exp 0 0", overflow_err, misalign_err);
        end
        tick;
        do_load("lw_0x100_old", 32'h100, F3_LW, 32'hA000_0000);
        do_load("lw_0x104_old", 32'h104, F3_LW, 32'hA000_0001);
        do_load("lw_0x108_old", 32'h108, F3_LW, 32'hA000_0002);
    endtask

    initial begin
        test_reset;
        test_sw_lw;
        test_sh_lbu;
        test_conflict;
        test_back_to_back;
        test_misalign_nonstore;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
